vfpu_seq: RTL and testbench

Sequential, parametrised vector floating-point unit for the vector datapath: executes element-wise vector add (VADD), vector dot product (VDOT) and scalar-by-vector multiply (SMUL) on IEEE-754 half-precision lanes. It replaces the single-cycle combinational unit with a start/done handshake, a configurable lane count, and a configurable number of lanes processed per cycle, so that lane hardware can be traded for latency. It sits between the vector/scalar register file read ports and the writeback mux; the overflow path reports the faulting instruction word to the scalar writeback.

---
 rtl/vfpu_pkg.sv | 18 +
 rtl/fp_adder.sv | 66 ++++++
 rtl/fp_mul16.sv | 53 +++++
 rtl/vfpu_seq.sv | 161 ++++++++++++++++
 tb/tb_vfpu_seq.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vfpu_pkg.sv
// Shared encodings and constants for the sequential vector FP unit.
package vfpu_pkg;

  localparam logic [1:0] OpVadd = 2'b00;
  localparam logic [1:0] OpVdot = 2'b01;
  localparam logic [1:0] OpSmul = 2'b10;
  localparam logic [1:0] OpIll  = 2'b11;

  localparam logic [15:0] Fp16Zero = 16'h0000;
  localparam logic [15:0] Fp16Inf  = 16'h7C00;
  localparam logic [15:0] Fp16Qnan = 16'h7E00;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/fp_adder.sv
// FP16 adder: round-to-nearest-even, subnormals flushed, NaN -> 0x7E00.
module fp_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o,
  output logic        ovf_o
);
  import vfpu_pkg::*;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [15:0] big, sml;
  logic [4:0]  d;
  logic [23:0] x, y_full, y_sh, n;
  logic [24:0] s;
  logic [11:0] m;
  int          p, e;
  logic        unused_hidden;

  assign unused_hidden = m[10];

  // Align the smaller magnitude, add/subtract, normalise, round, then resolve specials.
  always_comb begin
    a_nan  = (a_i[14:10] == 5'h1f) && (a_i[9:0] != 10'h0);
    b_nan  = (b_i[14:10] == 5'h1f) && (b_i[9:0] != 10'h0);
    a_inf  = (a_i[14:10] == 5'h1f) && (a_i[9:0] == 10'h0);
    b_inf  = (b_i[14:10] == 5'h1f) && (b_i[9:0] == 10'h0);
    a_zero = (a_i[14:10] == 5'h00);
    b_zero = (b_i[14:10] == 5'h00);
    swap   = b_i[14:0] > a_i[14:0];
    big    = swap ? b_i : a_i;
    sml    = swap ? a_i : b_i;
    d      = big[14:10] - sml[14:10];
    x      = {1'b1, big[9:0], 13'b0};
    y_full = {1'b1, sml[9:0], 13'b0};
    y_sh   = y_full >> d;
    // Bits shifted out are jammed into the LSB as a sticky bit.
    if ((y_sh << d) != y_full) y_sh[0] = 1'b1;
    s = (big[15] ^ sml[15]) ? ({1'b0, x} - {1'b0, y_sh}) : ({1'b0, x} + {1'b0, y_sh});
    p = 0;
    for (int i = 0; i < 25; i++) if (s[i]) p = i;
    e = int'(big[14:10]) - 23 + p;
    if (p == 24) n = {s[24:2], s[1] | s[0]};
    else         n = s[23:0] << (23 - p);
    m = {1'b0, n[23:13]} + {11'b0, n[12] & ((|n[11:0]) | n[13])};
    if (m[11]) begin
      e = e + 1;
      m = m >> 1;
    end
    sum_o = Fp16Zero;
    ovf_o = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_i[15] != b_i[15]))) sum_o = Fp16Qnan;
    else if (a_inf)               sum_o = a_i;
    else if (b_inf)               sum_o = b_i;
    else if (a_zero && b_zero)    sum_o = {a_i[15] & b_i[15], 15'b0};
    else if (a_zero)              sum_o = b_i;
    else if (b_zero)              sum_o = a_i;
    else if (s == 25'd0)          sum_o = Fp16Zero;
    else if (e >= 31) begin
      sum_o = {big[15], Fp16Inf[14:0]};
      ovf_o = 1'b1;
    end
    else if (e <= 0)              sum_o = {big[15], 15'b0};
    else                          sum_o = {big[15], e[4:0], m[9:0]};
  end

endmodule

// File: rtl/fp_mul16.sv
// FP16 multiplier: round-to-nearest-even, subnormals flushed, NaN -> 0x7E00.
module fp_mul16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] prod_o,
  output logic        ovf_o
);
  import vfpu_pkg::*;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic [21:0] prod, n;
  logic [11:0] m;
  int          e;
  logic        unused_hidden;

  assign unused_hidden = m[10];

  // Multiply significands, normalise by at most one place, round, then resolve specials.
  always_comb begin
    a_nan  = (a_i[14:10] == 5'h1f) && (a_i[9:0] != 10'h0);
    b_nan  = (b_i[14:10] == 5'h1f) && (b_i[9:0] != 10'h0);
    a_inf  = (a_i[14:10] == 5'h1f) && (a_i[9:0] == 10'h0);
    b_inf  = (b_i[14:10] == 5'h1f) && (b_i[9:0] == 10'h0);
    a_zero = (a_i[14:10] == 5'h00);
    b_zero = (b_i[14:10] == 5'h00);
    sgn    = a_i[15] ^ b_i[15];
    prod   = {11'b0, 1'b1, a_i[9:0]} * {11'b0, 1'b1, b_i[9:0]};
    e      = int'(a_i[14:10]) + int'(b_i[14:10]) - 15;
    if (prod[21]) begin
      n = prod;
      e = e + 1;
    end else begin
      n = prod << 1;
    end
    m = {1'b0, n[21:11]} + {11'b0, n[10] & ((|n[9:0]) | n[11])};
    if (m[11]) begin
      e = e + 1;
      m = m >> 1;
    end
    prod_o = Fp16Zero;
    ovf_o  = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) prod_o = Fp16Qnan;
    else if (a_inf || b_inf)   prod_o = {sgn, Fp16Inf[14:0]};
    else if (a_zero || b_zero) prod_o = {sgn, 15'b0};
    else if (e >= 31) begin
      prod_o = {sgn, Fp16Inf[14:0]};
      ovf_o  = 1'b1;
    end
    else if (e <= 0)           prod_o = {sgn, 15'b0};
    else                       prod_o = {sgn, e[4:0], m[9:0]};
  end

endmodule

// File: rtl/vfpu_seq.sv
// Sequential vector FP unit: VADD / VDOT / SMUL over LANES fp16 lanes, PAR lanes per beat.
module vfpu_seq #(
  parameter int unsigned LANES = 16,
  parameter int unsigned PAR   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [15:0]           instr_i,
  input  logic [16*LANES-1:0]   va_i,
  input  logic [16*LANES-1:0]   vb_i,
  input  logic [15:0]           sa_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [16*LANES-1:0]   vout_o,
  output logic [15:0]           sout_o,
  output logic                  ovf_o,
  output logic                  err_o,
  output logic [15:0]           exc_instr_o
);
  import vfpu_pkg::*;

  localparam int unsigned Beats = LANES / PAR;
  localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [15:0]         instr_q, instr_d, sa_q, sa_d, acc_q, acc_d, sout_q, sout_d;
  logic [16*LANES-1:0] va_q, va_d, vb_q, vb_d, vout_q, vout_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d, err_q, err_d;

  logic [15:0]         add_a [PAR];
  logic [15:0]         add_b [PAR];
  logic [15:0]         add_s [PAR];
  logic [15:0]         mul_a [PAR];
  logic [15:0]         mul_b [PAR];
  logic [15:0]         mul_p [PAR];
  logic [PAR-1:0]      add_ovf, mul_ovf;

  for (genvar j = 0; j < PAR; j++) begin : g_lane
    fp_adder u_add (.a_i(add_a[j]), .b_i(add_b[j]), .sum_o(add_s[j]), .ovf_o(add_ovf[j]));
    fp_mul16 u_mul (.a_i(mul_a[j]), .b_i(mul_b[j]), .prod_o(mul_p[j]), .ovf_o(mul_ovf[j]));
  end

  // Multiplier operands: scalar x lane for SMUL; lane 0 takes va[k]*vb[k] for VDOT.
  always_comb begin
    for (int j = 0; j < PAR; j++) begin
      mul_a[j] = sa_q;
      mul_b[j] = va_q[16*(cnt_q*PAR + j) +: 16];
    end
    if (op_q == OpVdot) begin
      mul_a[0] = va_q[16*cnt_q +: 16];
      mul_b[0] = vb_q[16*cnt_q +: 16];
    end
  end

  // Adder operands: lane pairs for VADD; lane 0 accumulates the rounded product for VDOT.
  always_comb begin
    for (int j = 0; j < PAR; j++) begin
      add_a[j] = va_q[16*(cnt_q*PAR + j) +: 16];
      add_b[j] = vb_q[16*(cnt_q*PAR + j) +: 16];
    end
    if (op_q == OpVdot) begin
      add_a[0] = acc_q;
      add_b[0] = mul_p[0];
    end
  end

  // FSM and datapath next-state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    instr_d = instr_q;
    va_d    = va_q;
    vb_d    = vb_q;
    sa_d    = sa_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    vout_d  = vout_q;
    sout_d  = sout_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = op_i;
          instr_d = instr_i;
          va_d    = va_i;
          vb_d    = vb_i;
          sa_d    = sa_i;
          cnt_d   = '0;
          acc_d   = Fp16Zero;
          ovf_d   = 1'b0;
          err_d   = (op_i == OpIll);
          state_d = (op_i == OpIll) ? StDone : StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OpVdot) begin
          acc_d = add_s[0];
          ovf_d = ovf_q | mul_ovf[0] | add_ovf[0];
          if (cnt_q == CntW'(LANES - 1)) begin
            sout_d  = add_s[0];
            state_d = StDone;
          end
        end else begin
          for (int j = 0; j < PAR; j++) begin
            vout_d[16*(cnt_q*PAR + j) +: 16] = (op_q == OpVadd) ? add_s[j] : mul_p[j];
          end
          ovf_d = ovf_q | ((op_q == OpVadd) ? (|add_ovf) : (|mul_ovf));
          if (cnt_q == CntW'(Beats - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      instr_q <= 16'h0;
      va_q    <= '0;
      vb_q    <= '0;
      sa_q    <= 16'h0;
      cnt_q   <= '0;
      acc_q   <= Fp16Zero;
      vout_q  <= '0;
      sout_q  <= 16'h0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      instr_q <= instr_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      sa_q    <= sa_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vout_q  <= vout_d;
      sout_q  <= sout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign vout_o      = vout_q;
  assign sout_o      = sout_q;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;
  assign exc_instr_o = ovf_q ? instr_q : 16'h0;

endmodule

// File: tb/tb_vfpu_seq.sv
// Scoreboard bench for vfpu_seq (LANES=16, PAR=4).
module tb_vfpu_seq;

  localparam int unsigned LANES = 16;
  localparam int unsigned PAR   = 4;
  localparam int          VW    = 16 * LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [15:0]   instr_i = 16'h0;
  logic [15:0]   sa_i = 16'h0;
  logic [VW-1:0] va_i = '0;
  logic [VW-1:0] vb_i = '0;
  logic          busy_o, done_o, ovf_o, err_o;
  logic [VW-1:0] vout_o;
  logic [15:0]   sout_o, exc_instr_o;

  vfpu_seq #(.LANES(LANES), .PAR(PAR)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .instr_i(instr_i),
    .va_i(va_i), .vb_i(vb_i), .sa_i(sa_i), .busy_o(busy_o), .done_o(done_o),
    .vout_o(vout_o), .sout_o(sout_o), .ovf_o(ovf_o), .err_o(err_o),
    .exc_instr_o(exc_instr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vout;
    logic [15:0]   sout;
    logic          ovf;
    logic          err;
    logic [15:0]   exc;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [VW-1:0] m_vout = '0;
  logic [15:0]   m_sout = 16'h0;
  int            n_cmp = 0;
  int            n_err = 0;

  // Launch one op; returns on the falling edge after the accepting rising edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] instr,
                       input logic [VW-1:0] va, input logic [VW-1:0] vb,
                       input logic [15:0] sa);
    @(negedge clk);
    op_i = op; instr_i = instr; va_i = va; vb_i = vb; sa_i = sa; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    // Operands are captured at start; scrambling them must not matter.
    va_i = ~va; vb_i = ~vb; sa_i = ~sa; instr_i = ~instr;
  endtask

  // Count cycles (rising edges since the start edge) until done_o, bounded.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done_o !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_cmp++; if (vout_o !== '0) begin n_err++; $display("FAIL rst_vout: got %h want 0", vout_o); end
    n_cmp++; if (sout_o !== 16'h0) begin n_err++; $display("FAIL rst_sout: got %h want 0", sout_o); end
    n_cmp++;
    if ({ovf_o, err_o, exc_instr_o} !== 18'h0) begin
      n_err++; $display("FAIL rst_flags: got %b %b %h want 0 0 0", ovf_o, err_o, exc_instr_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_vadd();
    exp_t e;
    int   cyc;
    e.vout = {LANES{16'h4200}}; e.sout = m_sout; e.ovf = 1'b0; e.err = 1'b0;
    e.exc = 16'h0; e.lat = LANES / PAR + 1;
    sb.push_back(e); m_vout = e.vout;
    issue(2'b00, 16'h0001, {LANES{16'h3C00}}, {LANES{16'h4000}}, 16'h0);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL vadd_lat: got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (vout_o !== e.vout) begin n_err++; $display("FAIL vadd_vout: got %h want %h", vout_o, e.vout); end
    n_cmp++; if (ovf_o !== e.ovf || err_o !== e.err) begin
      n_err++; $display("FAIL vadd_flags: got %b %b want %b %b", ovf_o, err_o, e.ovf, e.err);
    end
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL vadd_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_vdot_drop();
    exp_t e;
    int   cyc, nd;
    e.vout = m_vout; e.sout = 16'h5000; e.ovf = 1'b0; e.err = 1'b0; e.exc = 16'h0;
    e.lat = LANES + 1;
    sb.push_back(e); m_sout = e.sout;
    issue(2'b01, 16'h0002, {LANES{16'h3C00}}, {LANES{16'h4000}}, 16'h0);
    repeat (3) @(negedge clk);
    // A start during RUN must be dropped.
    op_i = 2'b00; va_i = {LANES{16'h7BFF}}; vb_i = {LANES{16'h7BFF}}; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(5, cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL vdot_lat: got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (sout_o !== e.sout) begin n_err++; $display("FAIL vdot_sout: got %h want %h", sout_o, e.sout); end
    n_cmp++; if (vout_o !== e.vout) begin n_err++; $display("FAIL vdot_vout: got %h want %h", vout_o, e.vout); end
    n_cmp++; if (ovf_o !== e.ovf) begin n_err++; $display("FAIL vdot_ovf: got %b want %b", ovf_o, e.ovf); end
    nd = 0;
    repeat (25) begin @(negedge clk); if (done_o === 1'b1) nd++; end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL drop_extra_done: got %0d want 0", nd); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_smul();
    exp_t e;
    int   cyc;
    e.vout = {LANES{16'h3E00}}; e.sout = m_sout; e.ovf = 1'b0; e.err = 1'b0;
    e.exc = 16'h0; e.lat = LANES / PAR + 1;
    sb.push_back(e); m_vout = e.vout;
    issue(2'b10, 16'h0003, {LANES{16'h4200}}, {LANES{16'h1234}}, 16'h3800);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL smul_lat: got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (vout_o !== e.vout) begin n_err++; $display("FAIL smul_vout: got %h want %h", vout_o, e.vout); end
    n_cmp++; if (sout_o !== e.sout) begin n_err++; $display("FAIL smul_sout: got %h want %h", sout_o, e.sout); end
  endtask

  // Distinct per-lane values catch lane mis-steering; lanes 14/15 probe tie rounding.
  task automatic test_lanes();
    exp_t          e;
    int            cyc;
    logic [VW-1:0] va, vb, ev;
    for (int i = 0; i < LANES; i++) begin
      va[16*i +: 16] = {1'b0, 5'(16 + i % 8), 10'(i * 37)};
      ev[16*i +: 16] = {1'b0, 5'(17 + i % 8), 10'(i * 37)};
    end
    vb = va;
    va[16*14 +: 16] = 16'h3C00; vb[16*14 +: 16] = 16'h1000; ev[16*14 +: 16] = 16'h3C00;
    va[16*15 +: 16] = 16'h3C01; vb[16*15 +: 16] = 16'h1000; ev[16*15 +: 16] = 16'h3C02;
    e.vout = ev; e.sout = m_sout; e.ovf = 1'b0; e.err = 1'b0; e.exc = 16'h0;
    e.lat = LANES / PAR + 1;
    sb.push_back(e); m_vout = ev;
    issue(2'b00, 16'h0004, va, vb, 16'h0);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (vout_o !== e.vout) begin n_err++; $display("FAIL lanes_vadd: got %h want %h", vout_o, e.vout); end
    for (int i = 0; i < 14; i++) ev[16*i +: 16] = {1'b0, 5'(15 + i % 8), 10'(i * 37)};
    ev[16*14 +: 16] = 16'h3800; ev[16*15 +: 16] = 16'h3801;
    e.vout = ev;
    sb.push_back(e); m_vout = ev;
    issue(2'b10, 16'h0005, va, vb, 16'h3800);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (vout_o !== e.vout) begin n_err++; $display("FAIL lanes_smul: got %h want %h", vout_o, e.vout); end
  endtask

  task automatic test_overflow();
    exp_t          e;
    int            cyc;
    logic [VW-1:0] va, vb;
    va = {LANES{16'h3C00}}; vb = {LANES{16'h4000}};
    va[16*7 +: 16] = 16'h7BFF; vb[16*7 +: 16] = 16'h7BFF;
    e.vout = {LANES{16'h4200}}; e.vout[16*7 +: 16] = 16'h7C00;
    e.sout = m_sout; e.ovf = 1'b1; e.err = 1'b0; e.exc = 16'hA5C3; e.lat = LANES / PAR + 1;
    sb.push_back(e); m_vout = e.vout;
    issue(2'b00, 16'hA5C3, va, vb, 16'h0);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (vout_o !== e.vout) begin n_err++; $display("FAIL ovf_vout: got %h want %h", vout_o, e.vout); end
    n_cmp++; if (ovf_o !== e.ovf) begin n_err++; $display("FAIL ovf_flag: got %b want %b", ovf_o, e.ovf); end
    n_cmp++; if (exc_instr_o !== e.exc) begin
      n_err++; $display("FAIL ovf_exc: got %h want %h", exc_instr_o, e.exc);
    end
    e.vout = {LANES{16'h4200}}; e.ovf = 1'b0; e.exc = 16'h0;
    sb.push_back(e); m_vout = e.vout;
    issue(2'b00, 16'h1111, {LANES{16'h3C00}}, {LANES{16'h4000}}, 16'h0);
    n_cmp++; if (ovf_o !== 1'b0 || exc_instr_o !== 16'h0) begin
      n_err++; $display("FAIL ovf_clear: got %b %h want 0 0000", ovf_o, exc_instr_o);
    end
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (vout_o !== e.vout || ovf_o !== e.ovf) begin
      n_err++; $display("FAIL ovf_next: got %h %b want %h %b", vout_o, ovf_o, e.vout, e.ovf);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int   cyc;
    e.vout = m_vout; e.sout = m_sout; e.ovf = 1'b0; e.err = 1'b1; e.exc = 16'h0; e.lat = 1;
    sb.push_back(e);
    issue(2'b11, 16'h00FF, {LANES{16'h1111}}, {LANES{16'h2222}}, 16'h3333);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL ill_lat: got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (err_o !== e.err) begin n_err++; $display("FAIL ill_err: got %b want %b", err_o, e.err); end
    n_cmp++; if (vout_o !== e.vout || sout_o !== e.sout) begin
      n_err++; $display("FAIL ill_hold: got %h %h want %h %h", vout_o, sout_o, e.vout, e.sout);
    end
  endtask

  // Issue in the cycle right after done_o.
  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    e.vout = {LANES{16'h4200}}; e.sout = m_sout; e.ovf = 1'b0; e.err = 1'b0;
    e.exc = 16'h0; e.lat = LANES / PAR + 1;
    sb.push_back(e); m_vout = e.vout;
    issue(2'b00, 16'h0006, {LANES{16'h3C00}}, {LANES{16'h4000}}, 16'h0);
    n_cmp++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept: got err=%b busy=%b want err=0 busy=1", err_o, busy_o);
    end
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL b2b_lat: got %0d want %0d", cyc, e.lat); end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int   cyc, nd;
    issue(2'b01, 16'h0007, {LANES{16'h3C00}}, {LANES{16'h4000}}, 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_state: got busy=%b done=%b want 0 0", busy_o, done_o);
    end
    n_cmp++; if (vout_o !== '0 || sout_o !== 16'h0 || ovf_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_outs: got %h %h %b %b want all 0", vout_o, sout_o, ovf_o, err_o);
    end
    nd = 0;
    repeat (20) begin @(negedge clk); if (done_o === 1'b1) nd++; end
    rst = 1'b0;
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL midrst_done: got %0d want 0", nd); end
    m_vout = '0; m_sout = 16'h0;
    e.vout = {LANES{16'h4200}}; e.sout = 16'h0; e.ovf = 1'b0; e.err = 1'b0;
    e.exc = 16'h0; e.lat = LANES / PAR + 1;
    sb.push_back(e); m_vout = e.vout;
    issue(2'b00, 16'h0008, {LANES{16'h3C00}}, {LANES{16'h4000}}, 16'h0);
    wait_done(1, cyc);
    e = sb.pop_front();
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL postrst_lat: got %0d want %0d", cyc, e.lat); end
    n_cmp++; if (vout_o !== e.vout || sout_o !== e.sout) begin
      n_err++; $display("FAIL postrst_res: got %h %h want %h %h", vout_o, sout_o, e.vout, e.sout);
    end
  endtask

  initial begin
    test_reset();
    test_vadd();
    test_vdot_drop();
    test_smul();
    test_lanes();
    test_overflow();
    test_illegal();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
